// File: rtl/jtframe_mfrac_cen_pkg.sv
// jtframe_mfrac_cen_pkg
//   Shared types and constants for the fractional clock-enable generator.
//   NW_DEF  : default numerator/denominator width
//   ACC_W   : accumulator width (one extra bit so acc + n never overflows)
//   CHI_W   : width of the configuration channel index
//   ratio_t : n/m ratio pair
//   RESET_RATIO : ratio loaded at reset (1/2, half rate)
package jtframe_mfrac_cen_pkg;
  localparam int NW_DEF = 10;
  localparam int ACC_W  = NW_DEF + 1;
  localparam int CHI_W  = 3;

  typedef struct packed {
    logic [NW_DEF-1:0] n;
    logic [NW_DEF-1:0] m;
  } ratio_t;

  localparam ratio_t RESET_RATIO = '{n: NW_DEF'(1), m: NW_DEF'(2)};
endpackage

// File: rtl/jtframe_mfrac_cen_if.sv
// jtframe_mfrac_cen_if
//   Ratio configuration bus.
//   cfg_we : write strobe for the staging register of cfg_ch
//   cfg_ch : target channel (indices >= CH are ignored by the block)
//   cfg_n  : numerator to stage
//   cfg_m  : denominator to stage
//   master drives the bus, slave (the cen generator) receives it.
interface jtframe_mfrac_cen_if #(
  parameter int NW    = 10,
  parameter int CHI_W = 3
);
  logic             cfg_we;
  logic [CHI_W-1:0] cfg_ch;
  logic [NW-1:0]    cfg_n;
  logic [NW-1:0]    cfg_m;

  modport master (output cfg_we, cfg_ch, cfg_n, cfg_m);
  modport slave  (input  cfg_we, cfg_ch, cfg_n, cfg_m);
endinterface

// File: rtl/jtframe_mfrac_cen_ch.sv
// jtframe_mfrac_cen_ch
//   One channel of the fractional cen generator: accumulator, staged and
//   active ratio, edge counter for the binary-divided outputs, sticky error.
//   Optional half-period outputs (cenb) when JTFRAME_MFRAC_CEN_HALF_EN is
//   defined; otherwise cenb is tied to zero.
//   clk, rst     : clock, async active-high reset
//   cen_in, en   : counting qualifier and channel enable
//   sync         : restart accumulator/edge/half and apply pending ratio
//   we, n_in,m_in: decoded write of the staging register
//   cen, cenb    : registered one-cycle pulses, bit k = base rate / 2^k
//   err          : sticky error (rejected write or accumulator out of range)
module jtframe_mfrac_cen_ch
  import jtframe_mfrac_cen_pkg::*;
#(
  parameter int W  = 2,
  parameter int NW = NW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen_in,
  input  logic          en,
  input  logic          sync,
  input  logic          we,
  input  logic [NW-1:0] n_in,
  input  logic [NW-1:0] m_in,
  output logic [W-1:0]  cen,
  output logic [W-1:0]  cenb,
  output logic          err
);
  localparam int AW = NW + 1;

  logic [AW-1:0] acc, nxt, lim;
  logic [NW-1:0] act_n, act_m, stg_n, stg_m;
  logic          pend, count, guard, over, apply, wr_ok;
  logic [W-2:0]  edge_cnt, edge_nxt;
  logic [W-1:0]  cen_nxt;

  always_comb begin
    count    = cen_in & en & ~sync;
    nxt      = acc + AW'(act_n);
    lim      = AW'(act_m) + AW'(act_n);
    guard    = count & (acc >= lim);
    over     = count & ~guard & (nxt >= AW'(act_m));
    // a staged ratio waits for the next over event unless the channel is idle
    apply    = pend & (sync | over | ~en);
    wr_ok    = (n_in != '0) && (m_in != '0) && (n_in <= m_in);
    edge_nxt = edge_cnt + (W-1)'(1);
    cen_nxt  = '0;
    cen_nxt[0] = over;
    for (int k = 1; k < W; k++)
      cen_nxt[k] = over & ~edge_cnt[k-1] & edge_nxt[k-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      edge_cnt <= '0;
      act_n    <= NW'(RESET_RATIO.n);
      act_m    <= NW'(RESET_RATIO.m);
      stg_n    <= NW'(RESET_RATIO.n);
      stg_m    <= NW'(RESET_RATIO.m);
      pend     <= 1'b0;
      cen      <= '0;
      err      <= 1'b0;
    end else begin
      cen <= cen_nxt;
      if (sync) begin
        acc      <= '0;
        edge_cnt <= '0;
      end else if (guard) begin
        acc <= '0;
      end else if (over) begin
        acc      <= nxt - AW'(act_m);
        edge_cnt <= edge_nxt;
      end else if (count) begin
        acc <= nxt;
      end
      if (apply) begin
        act_n <= stg_n;
        act_m <= stg_m;
        pend  <= 1'b0;
      end
      // a write in the apply cycle re-stages and stays pending
      if (we && wr_ok) begin
        stg_n <= n_in;
        stg_m <= m_in;
        pend  <= 1'b1;
      end
      if (guard || (we && !wr_ok))
        err <= 1'b1;
      else if (we && wr_ok)
        err <= 1'b0;
    end
  end

`ifdef JTFRAME_MFRAC_CEN_HALF_EN
  logic         half, half_ev;
  logic [W-2:0] arm;
  logic [W-1:0] cenb_nxt;

  always_comb begin
    half_ev  = count & ~guard & ~over & ~half & (nxt >= (AW'(act_m) >> 1));
    cenb_nxt = '0;
    cenb_nxt[0] = half_ev;
    for (int k = 1; k < W; k++)
      cenb_nxt[k] = half_ev & arm[k-1];
  end

  // arm[k-1] remembers a cen[k] pulse until the following half event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half <= 1'b0;
      arm  <= '0;
      cenb <= '0;
    end else begin
      cenb <= cenb_nxt;
      if (sync) begin
        half <= 1'b0;
        arm  <= '0;
      end else begin
        if (over || guard)
          half <= 1'b0;
        else if (half_ev)
          half <= 1'b1;
        arm <= (half_ev ? '0 : arm) | cen_nxt[W-1:1];
      end
    end
  end
`else
  assign cenb = '0;
`endif
endmodule

// File: rtl/jtframe_mfrac_cen.sv
// jtframe_mfrac_cen
//   Multi-channel fractional clock-enable generator. Each channel emits cen
//   pulses at n/m of the cen_in rate plus W-1 binary-divided copies.
//   Optional macro: JTFRAME_MFRAC_CEN_HALF_EN enables the 180-degree cenb
//   outputs; without it cenb is constant zero.
//   clk, rst : clock, async active-high reset
//   cen_in   : global counting qualifier
//   en       : per-channel enable
//   sync     : restart all channels in phase
//   cfg      : ratio configuration bus (slave)
//   cen/cenb : pulses, channel c bit k at [c*W+k]
//   err      : per-channel sticky error
module jtframe_mfrac_cen
  import jtframe_mfrac_cen_pkg::*;
#(
  parameter int CH = 2,
  parameter int W  = 2,
  parameter int NW = NW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cen_in,
  input  logic [CH-1:0]        en,
  input  logic                 sync,
  jtframe_mfrac_cen_if.slave   cfg,
  output logic [CH*W-1:0]      cen,
  output logic [CH*W-1:0]      cenb,
  output logic [CH-1:0]        err
);
  for (genvar c = 0; c < CH; c++) begin : g_ch
    jtframe_mfrac_cen_ch #(
      .W  (W),
      .NW (NW)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .cen_in (cen_in),
      .en     (en[c]),
      .sync   (sync),
      .we     (cfg.cfg_we && (cfg.cfg_ch == CHI_W'(c))),
      .n_in   (cfg.cfg_n),
      .m_in   (cfg.cfg_m),
      .cen    (cen[c*W +: W]),
      .cenb   (cenb[c*W +: W]),
      .err    (err[c])
    );
  end
endmodule

// File: tb/tb_jtframe_mfrac_cen.sv
module tb_jtframe_mfrac_cen;
  localparam int CH = 2;
  localparam int W  = 2;
  localparam int NW = 10;

  logic clk = 1'b0;
  logic rst, cen_in, sync;
  logic [CH-1:0]   en;
  logic [CH*W-1:0] cen, cenb;
  logic [CH-1:0]   err;
  int checks = 0;
  int errors = 0;

  jtframe_mfrac_cen_if #(.NW(NW)) cfg_bus();

  jtframe_mfrac_cen #(.CH(CH), .W(W), .NW(NW)) dut (
    .clk    (clk),
    .rst    (rst),
    .cen_in (cen_in),
    .en     (en),
    .sync   (sync),
    .cfg    (cfg_bus),
    .cen    (cen),
    .cenb   (cenb),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input logic [2:0] ch, input logic [NW-1:0] n, input logic [NW-1:0] m);
    cfg_bus.cfg_we = 1'b1;
    cfg_bus.cfg_ch = ch;
    cfg_bus.cfg_n  = n;
    cfg_bus.cfg_m  = m;
    tick();
    cfg_bus.cfg_we = 1'b0;
  endtask

  // stage with the channel disabled so the ratio applies on the following cycle
  task automatic set_ratio(input int ch, input int n, input int m);
    logic [CH-1:0] en_save;
    en_save = en;
    en[ch]  = 1'b0;
    write_cfg(3'(ch), NW'(n), NW'(m));
    tick();
    en = en_save;
  endtask

  task automatic do_sync();
    sync = 1'b1;
    tick();
    sync = 1'b0;
    checks++;
    if (cen !== '0) begin
      errors++;
      $display("FAIL sync_no_pulse: cen=%b expected %b", cen, 4'b0000);
    end
  endtask

  task automatic test_reset();
    logic [7:0] p0, p1;
    logic [3:0] exp;
    p0 = 8'b1010_1010;
    p1 = 8'b0010_0010;
    rst = 1'b1; cen_in = 1'b1; en = 2'b11; sync = 1'b0;
    cfg_bus.cfg_we = 1'b0; cfg_bus.cfg_ch = '0; cfg_bus.cfg_n = '0; cfg_bus.cfg_m = '0;
    repeat (3) tick();
    checks++;
    if ({cen, cenb, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: cen=%b cenb=%b err=%b expected all 0", cen, cenb, err);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp = {p1[i], p0[i], p1[i], p0[i]};
      checks++;
      if (cen !== exp) begin
        errors++;
        $display("FAIL default_ratio[%0d]: cen=%b expected %b", i, cen, exp);
      end
`ifndef JTFRAME_MFRAC_CEN_HALF_EN
      checks++;
      if (cenb !== '0) begin
        errors++;
        $display("FAIL cenb_tied[%0d]: cenb=%b expected 0", i, cenb);
      end
`endif
    end
  endtask

  task automatic test_ratio_3_10();
    int cnt0, cnt1, last, first;
    set_ratio(0, 3, 10);
    en = 2'b11;
    do_sync();
    cnt0 = 0; cnt1 = 0; last = 0; first = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (cen[1]) cnt1++;
      if (cen[0]) begin
        cnt0++;
        if (last == 0) first = k;
        else begin
          checks++;
          if ((k - last) != 3 && (k - last) != 4) begin
            errors++;
            $display("FAIL spacing_3_10: gap=%0d expected 3 or 4", k - last);
          end
        end
        last = k;
      end
    end
    checks++;
    if (first !== 4) begin
      errors++;
      $display("FAIL first_pulse_3_10: at %0d expected 4", first);
    end
    checks++;
    if (cnt0 !== 30) begin
      errors++;
      $display("FAIL count_3_10: cen0 pulses=%0d expected 30", cnt0);
    end
    checks++;
    if (cnt1 !== 15) begin
      errors++;
      $display("FAIL count_div2_3_10: cen1 pulses=%0d expected 15", cnt1);
    end
  endtask

  task automatic test_mid_write();
    logic [24:0] exp;
    exp = 25'h0444490;  // pulses at 4,7,10 (3/10), then 14,18,22 (1/4)
    en = 2'b11;
    do_sync();
    for (int k = 1; k <= 24; k++) begin
      if (k == 5) begin
        cfg_bus.cfg_we = 1'b1; cfg_bus.cfg_ch = 3'd0;
        cfg_bus.cfg_n = NW'(1); cfg_bus.cfg_m = NW'(4);
      end else cfg_bus.cfg_we = 1'b0;
      tick();
      checks++;
      if (cen[0] !== exp[k]) begin
        errors++;
        $display("FAIL mid_write[%0d]: cen0=%b expected %b", k, cen[0], exp[k]);
      end
    end
    cfg_bus.cfg_we = 1'b0;
  endtask

  task automatic test_invalid();
    logic [20:0] exp;
    logic        exp_err;
    exp = 21'h049110;   // 4,8,12 at 1/4, then 15,18 at 1/3
    en  = 2'b11;
    do_sync();
    for (int k = 1; k <= 20; k++) begin
      cfg_bus.cfg_we = 1'b0;
      if (k == 1) begin
        cfg_bus.cfg_we = 1'b1; cfg_bus.cfg_ch = 3'd0;
        cfg_bus.cfg_n = NW'(5); cfg_bus.cfg_m = NW'(3);
      end else if (k == 2) begin
        cfg_bus.cfg_we = 1'b1; cfg_bus.cfg_ch = 3'd5;
        cfg_bus.cfg_n = NW'(0); cfg_bus.cfg_m = NW'(0);
      end else if (k == 9) begin
        cfg_bus.cfg_we = 1'b1; cfg_bus.cfg_ch = 3'd0;
        cfg_bus.cfg_n = NW'(1); cfg_bus.cfg_m = NW'(3);
      end
      tick();
      exp_err = (k < 9);
      checks++;
      if (err !== {1'b0, exp_err}) begin
        errors++;
        $display("FAIL invalid_err[%0d]: err=%b expected %b", k, err, {1'b0, exp_err});
      end
      checks++;
      if (cen[0] !== exp[k]) begin
        errors++;
        $display("FAIL invalid_ratio_kept[%0d]: cen0=%b expected %b", k, cen[0], exp[k]);
      end
    end
    cfg_bus.cfg_we = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [14:0] exp;
    exp = 15'h2108;     // 3 at 1/3, then 8,13 at 1/5 (1/2 overwritten)
    en  = 2'b11;
    do_sync();
    for (int k = 1; k <= 14; k++) begin
      cfg_bus.cfg_we = (k == 1) || (k == 2);
      cfg_bus.cfg_ch = 3'd0;
      cfg_bus.cfg_n  = NW'(1);
      cfg_bus.cfg_m  = (k == 1) ? NW'(2) : NW'(5);
      tick();
      checks++;
      if (cen[0] !== exp[k]) begin
        errors++;
        $display("FAIL back_to_back[%0d]: cen0=%b expected %b", k, cen[0], exp[k]);
      end
    end
    cfg_bus.cfg_we = 1'b0;
  endtask

  task automatic test_equal();
    set_ratio(0, 4, 4);
    en = 2'b11;
    do_sync();
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (cen[1:0] !== {k[0], 1'b1}) begin
        errors++;
        $display("FAIL n_eq_m[%0d]: cen[1:0]=%b expected %b", k, cen[1:0], {k[0], 1'b1});
      end
    end
  endtask

  task automatic test_range_guard();
    set_ratio(0, 1, 5);
    en = 2'b11;
    do_sync();
    repeat (4) tick();          // acc reaches 4, no over yet
    en[0] = 1'b0;
    write_cfg(3'd0, NW'(1), NW'(2));
    tick();                     // applied while idle, acc 4 >= 1+2
    en[0] = 1'b1;
    tick();
    checks++;
    if ({cen[0], err[0]} !== 2'b01) begin
      errors++;
      $display("FAIL range_guard: cen0=%b err0=%b expected cen0=0 err0=1", cen[0], err[0]);
    end
    tick();
    checks++;
    if (cen[0] !== 1'b0) begin
      errors++;
      $display("FAIL range_restart1: cen0=%b expected 0", cen[0]);
    end
    tick();
    checks++;
    if (cen[0] !== 1'b1) begin
      errors++;
      $display("FAIL range_restart2: cen0=%b expected 1", cen[0]);
    end
    write_cfg(3'd0, NW'(1), NW'(2));
    checks++;
    if (err[0] !== 1'b0) begin
      errors++;
      $display("FAIL range_err_clear: err0=%b expected 0", err[0]);
    end
  endtask

  task automatic test_sync_align();
    int first0, first1;
    set_ratio(0, 1, 3);
    set_ratio(1, 1, 5);
    en = 2'b11;
    repeat (7) tick();
    do_sync();
    first0 = 0; first1 = 0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (cen[0] && first0 == 0) first0 = k;
      if (cen[2] && first1 == 0) first1 = k;
      if (k == 15) begin
        checks++;
        if ({cen[2], cen[0]} !== 2'b11) begin
          errors++;
          $display("FAIL sync_coincide: cen2=%b cen0=%b expected 1 1", cen[2], cen[0]);
        end
      end
    end
    checks++;
    if (first0 !== 3) begin
      errors++;
      $display("FAIL sync_first_ch0: at %0d expected 3", first0);
    end
    checks++;
    if (first1 !== 5) begin
      errors++;
      $display("FAIL sync_first_ch1: at %0d expected 5", first1);
    end
  endtask

`ifdef JTFRAME_MFRAC_CEN_HALF_EN
  task automatic test_half();
    int a;
    logic act;
    logic [3:0] exp;
    set_ratio(0, 1, 4);
    en = 2'b10;
    do_sync();
    a = 0;
    for (int i = 1; i <= 30; i++) begin
      act   = !(i >= 10 && i <= 19);
      en[0] = act;
      tick();
      if (act) a++;
      exp[0] = act && (a % 4 == 0);   // cen0
      exp[1] = act && (a % 8 == 4);   // cen1
      exp[2] = act && (a % 4 == 2);   // cenb0
      exp[3] = act && (a % 8 == 6);   // cenb1
      checks++;
      if ({cenb[1:0], cen[1:0]} !== exp) begin
        errors++;
        $display("FAIL half[%0d]: cenb=%b cen=%b expected cenb=%b cen=%b",
                 i, cenb[1:0], cen[1:0], exp[3:2], exp[1:0]);
      end
    end
    en = 2'b11;
  endtask
`endif

  initial begin
    test_reset();
    test_ratio_3_10();
    test_mid_write();
    test_invalid();
    test_back_to_back();
    test_equal();
    test_range_guard();
    test_sync_align();
`ifdef JTFRAME_MFRAC_CEN_HALF_EN
    test_half();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
